// File: rtl/load_store_unit.sv
// Load/store unit: sized, big-endian loads and stores over a word memory.
// Sub-word stores read the word first, then write back a merged word.
module load_store_unit (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nxt, start_state;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        mis_q, mis_in, accept, load_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val, merged;

    assign accept = req && (state == IDLE || state == DONE);
    assign load_q = (op_q <= OP_LBU);

    always_comb begin
        mis_in = 1'b0;
        case (op)
            OP_LW, OP_SW:         mis_in = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis_in = addr[0];
            default:              mis_in = 1'b0;
        endcase
    end

    always_comb begin
        start_state = READ;
        if (mis_in)
            start_state = DONE;
        else if (op == OP_SW)
            start_state = WRITE;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = start_state;
            READ:  state_nxt = load_q ? DONE : WRITE;
            WRITE: state_nxt = DONE;
            DONE:  state_nxt = accept ? start_state : IDLE;
        endcase
    end

    // Offset 0 is the most significant lane of the word.
    always_comb begin
        byte_sel = mem_rd[31:24];
        case (addr_q[1:0])
            2'd0: byte_sel = mem_rd[31:24];
            2'd1: byte_sel = mem_rd[23:16];
            2'd2: byte_sel = mem_rd[15:8];
            2'd3: byte_sel = mem_rd[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rd[15:0] : mem_rd[31:16];
    end

    always_comb begin
        ld_val = mem_rd;
        case (op_q)
            OP_LH:   ld_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_val = {16'h0, half_sel};
            OP_LB:   ld_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_val = {24'h0, byte_sel};
            default: ld_val = mem_rd;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (op_q)
            OP_SB: begin
                case (addr_q[1:0])
                    2'd0: merged[31:24] = wdata_q[7:0];
                    2'd1: merged[23:16] = wdata_q[7:0];
                    2'd2: merged[15:8]  = wdata_q[7:0];
                    2'd3: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            OP_SH: begin
                if (addr_q[1])
                    merged[15:0] = wdata_q[15:0];
                else
                    merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                mis_q   <= mis_in;
            end
            if (state == READ) begin
                word_q <= mem_rd;
                if (load_q)
                    rdata <= ld_val;
            end
        end
    end

    assign busy     = (state == READ) || (state == WRITE);
    assign done     = (state == DONE);
    assign misalign = (state == DONE) && mis_q;
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_we   = (state == WRITE) && !reset;
    assign mem_wd   = merged;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock, CLK; reset is synchronous, active-high, named reset; all state updates on posedge CLK.
REQ-002 Ports, one per line (name  direction  width  meaning):
- CLK  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  1  access request, sampled on posedge
- op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb
- addr  in  32  byte address
- wdata  in  32  store data; sh uses [15:0], sb uses [7:0]
- busy  out  1  access in progress, request not accepted
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid with done: access was misaligned and suppressed
- rdata  out  32  extended load result, valid from done until the next accepted load
- mem_addr  out  32  word-aligned memory address {addr_q[31:2],2'b00}
- mem_we  out  1  memory write enable; memory writes on negedge of the same cycle
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_addr

Function
REQ-003 States SHALL be IDLE, READ, WRITE, DONE.
REQ-004 A request SHALL be accepted on a posedge with req=1 in state IDLE or DONE; on acceptance op, addr and wdata are latched (op_q, addr_q, wdata_q).
REQ-005 busy SHALL equal 1 in READ and WRITE, and 0 in IDLE and DONE; req while busy is ignored.
REQ-006 Misaligned means: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]!=0; byte ops are never misaligned.
REQ-007 Transitions on acceptance:
- misaligned -> DONE
- any load, sb, sh -> READ
- sw -> WRITE
REQ-008 From READ: loads -> DONE; sb/sh -> WRITE.
REQ-009 From WRITE: -> DONE.
REQ-010 From DONE: -> READ/WRITE/DONE per REQ-007 if a new request is accepted, else -> IDLE.
REQ-011 Latency from the accepting edge to the done=1 cycle SHALL be:
- misaligned: 1 cycle
- loads and sw: 2 cycles
- sb/sh: 3 cycles
REQ-012 Byte order SHALL be big-endian: offset 0 is word bits [31:24], offset 3 is [7:0]; halfword offset 0 is [31:16], offset 2 is [15:0].
REQ-013 On the posedge leaving READ:
- the word mem_rd SHALL be captured into word_q
- for loads, rdata SHALL load the selected lane: lb/lh sign-extended, lbu/lhu zero-extended, lw unmodified
REQ-014 mem_wd SHALL be:
- sw: wdata_q
- sb/sh: word_q with only the addressed lane replaced by wdata_q[7:0] or wdata_q[15:0]
REQ-015 mem_we SHALL be 1 only in WRITE with reset=0; it is high for exactly one cycle per store, and 0 for loads and misaligned accesses.
REQ-016 done SHALL be 1 exactly in DONE; misalign SHALL be 1 in DONE only for a misaligned access.
REQ-017 rdata SHALL be unchanged by stores and misaligned accesses.

Reset
REQ-018 While reset=1, mem_we SHALL be 0 combinationally; the current-cycle write is suppressed even in WRITE.
REQ-019 At the posedge with reset=1:
- state -> IDLE
- rdata, word_q, addr_q, wdata_q, op_q -> 0
- a req in the same cycle is ignored
REQ-020 After reset: busy=0, done=0, misalign=0, mem_addr=0, mem_wd=0.
REQ-021 An in-flight access aborted by reset SHALL produce no done pulse and no memory modification.

Verification
REQ-022 Memory word 0x20 = 0x8899AABB:
- lb 0x20 -> rdata 0xFFFFFF88
- lbu 0x23 -> 0x000000BB
- lh 0x22 -> 0xFFFFAABB
- lhu 0x20 -> 0x00008899
- each with done exactly 2 cycles after accept
REQ-023 sb addr 0x21 wdata 0x12345655 -> word 0x20 becomes 0x8855AABB; mem_we high exactly one cycle; done 3 cycles after accept; rdata unchanged.
REQ-024 sw addr 0x26 -> misalign=1 with done 1 cycle after accept; mem_we never high; memory unchanged.
REQ-025 sh addr 0x22 wdata 0x0000CAFE with reset=1 during the WRITE cycle -> mem_we=0, word stays 0x8899AABB, no done, busy=0 next cycle.
REQ-026 Back-to-back:
- req held high: sw 0x30 = 0xDEADBEEF, then lw 0x30 accepted in the DONE cycle
- required: lw done 2 cycles later with rdata 0xDEADBEEF; busy never high in a DONE cycle
